// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    byte_in,
   input  logic                          enable,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          bit_out,
   output logic                          busy
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic              PAR_ODD   = (PARITY_ODD != 0);
   localparam logic              PAR_EN    = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              ovf_q, ovf_d;

   state_e            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_q, par_d;
   logic              bit_q, bit_d;
   logic              busy_q, busy_d;

   logic              push;
   logic              pop;
   logic              bit_end;
   logic [7:0]        head;

   // Writes are accepted only against the registered full flag.
   assign push    = enable & ~full_q;
   assign head    = mem[rd_ptr_q];
   assign bit_end = (baud_q == BAUD_LAST);

   // FIFO storage; no reset needed, validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= byte_in;
   end

   // FIFO pointer, occupancy and flag next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      full_d   = (count_d == DEPTH_CNT);
      ovf_d    = enable & full_q;
   end

   // Serialiser next-state, pop request and registered line level.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + BAUD_W'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = head;
               par_d   = (^head) ^ PAR_ODD;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               baud_d  = '0;
               idx_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (idx_q == 3'd7) begin
                  idx_d   = '0;
                  state_d = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               baud_d  = '0;
               idx_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (idx_q == STOP_LAST) begin
                  idx_d = '0;
                  if (count_q != '0) begin
                     // Back-to-back frame: no idle bit between stop and start.
                     pop     = 1'b1;
                     shift_d = head;
                     par_d   = (^head) ^ PAR_ODD;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            baud_d  = '0;
            state_d = S_IDLE;
         end
      endcase

      case (state_d)
         S_START:  bit_d = 1'b0;
         S_DATA:   bit_d = shift_d[0];
         S_PARITY: bit_d = par_d;
         default:  bit_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State registers; reset abandons any frame and drives the line idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         baud_q   <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         bit_q    <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         bit_q    <= bit_d;
         busy_q   <= busy_d;
      end
   end

   assign full       = full_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;
   assign bit_out    = bit_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four transmitter configurations driven in lockstep, line checked every cycle.
module tb_uart_tx_fifo;

   logic       clk;
   logic       reset;
   logic [7:0] byte_in;
   logic       enable;

   logic [3:0] bo, bz, fl, ov;
   logic [3:0] fc [4];

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_b [16];

   // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2; all 4 clocks per bit, depth 8.
   uart_tx_fifo #(.CLKS_PER_BIT(4)) u_n1 (
      .clk(clk), .reset(reset), .byte_in(byte_in), .enable(enable),
      .full(fl[0]), .fifo_count(fc[0]), .overflow(ov[0]), .bit_out(bo[0]), .busy(bz[0]));
   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_e1 (
      .clk(clk), .reset(reset), .byte_in(byte_in), .enable(enable),
      .full(fl[1]), .fifo_count(fc[1]), .overflow(ov[1]), .bit_out(bo[1]), .busy(bz[1]));
   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_o1 (
      .clk(clk), .reset(reset), .byte_in(byte_in), .enable(enable),
      .full(fl[2]), .fifo_count(fc[2]), .overflow(ov[2]), .bit_out(bo[2]), .busy(bz[2]));
   uart_tx_fifo #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_n2 (
      .clk(clk), .reset(reset), .byte_in(byte_in), .enable(enable),
      .full(fl[3]), .fifo_count(fc[3]), .overflow(ov[3]), .bit_out(bo[3]), .busy(bz[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int pe_of(input int i);
      return (i == 1 || i == 2) ? 1 : 0;
   endfunction

   function automatic int po_of(input int i);
      return (i == 2) ? 1 : 0;
   endfunction

   function automatic int sb_of(input int i);
      return (i == 3) ? 2 : 1;
   endfunction

   function automatic int flen(input int i);
      return 4 * (9 + pe_of(i) + sb_of(i));
   endfunction

   // Expected line level during bit slot b of a frame carrying d.
   function automatic int exp_bit(input int i, input logic [7:0] d, input int b);
      if (b == 0) return 0;
      if (b <= 8) return int'(d[b-1]);
      if (pe_of(i) == 1 && b == 9) return int'(^d) ^ po_of(i);
      return 1;
   endfunction

   // Checks line and busy each cycle; c=0 is the cycle after the edge that popped the first byte.
   task automatic observe(input int c_start, input int nfr);
      for (int c = c_start; c <= nfr * 44; c++) begin
         for (int i = 0; i < 4; i++) begin
            int f;
            f = c / flen(i);
            if (f < nfr) begin
               check($sformatf("bit u%0d c%0d", i, c), int'(bo[i]),
                     exp_bit(i, exp_b[f], (c % flen(i)) / 4));
               check($sformatf("busy u%0d c%0d", i, c), int'(bz[i]), 1);
            end else begin
               check($sformatf("idle_bit u%0d c%0d", i, c), int'(bo[i]), 1);
               check($sformatf("idle_busy u%0d c%0d", i, c), int'(bz[i]), 0);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic check_all_reset(input string tag);
      check({tag, "_bit"}, int'(bo), 15);
      check({tag, "_busy"}, int'(bz), 0);
      check({tag, "_full"}, int'(fl), 0);
      check({tag, "_ovf"}, int'(ov), 0);
      for (int i = 0; i < 4; i++) check($sformatf("%s_cnt u%0d", tag, i), int'(fc[i]), 0);
   endtask

   task automatic write_single(input logic [7:0] b);
      byte_in = b;
      enable  = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("cnt_after_wr u%0d", i), int'(fc[i]), 1);
      enable = 1'b0;
      @(negedge clk);
      exp_b[0] = b;
      observe(0, 1);
   endtask

   task automatic write_pair(input logic [7:0] b0, input logic [7:0] b1);
      byte_in = b0;
      enable  = 1'b1;
      @(negedge clk);
      byte_in = b1;
      @(negedge clk);
      enable = 1'b0;
      exp_b[0] = b0;
      exp_b[1] = b1;
      observe(0, 2);
   endtask

   initial begin
      reset   = 1'b1;
      byte_in = 8'h00;
      enable  = 1'b0;
      repeat (2) @(negedge clk);
      check_all_reset("rst");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_all_reset("post_rst");

      // Single bytes: alternating pattern, then the parity case.
      write_single(8'h55);
      write_single(8'hA7);

      // Back-to-back frames, including the two-stop-bit gap.
      write_pair(8'h01, 8'h80);
      write_pair(8'hFF, 8'h00);

      // Ten writes in a row: nine accepted, one dropped with a single overflow pulse.
      for (int k = 0; k < 10; k++) begin
         byte_in = 8'(8'h10 + k);
         enable  = 1'b1;
         if (k < 9) exp_b[k] = 8'(8'h10 + k);
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            check($sformatf("burst_cnt u%0d k%0d", i, k), int'(fc[i]),
                  (k == 0) ? 1 : ((k > 8) ? 8 : k));
            check($sformatf("burst_full u%0d k%0d", i, k), int'(fl[i]), (k >= 8) ? 1 : 0);
            check($sformatf("burst_ovf u%0d k%0d", i, k), int'(ov[i]), (k == 9) ? 1 : 0);
         end
      end
      enable = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf_clear u%0d", i), int'(ov[i]), 0);
         check($sformatf("still_full u%0d", i), int'(fl[i]), 1);
         check($sformatf("still_cnt u%0d", i), int'(fc[i]), 8);
      end
      observe(9, 9);

      // Reset in the middle of data bit 3 with three bytes queued.
      for (int k = 0; k < 4; k++) begin
         byte_in = (k == 0) ? 8'h0F : 8'(8'hA0 + k);
         enable  = 1'b1;
         @(negedge clk);
      end
      enable = 1'b0;
      for (int i = 0; i < 4; i++) check($sformatf("queued u%0d", i), int'(fc[i]), 3);
      repeat (15) @(negedge clk);
      check("pre_rst_busy", int'(bz), 15);
      #2 reset = 1'b1;
      #1 check_all_reset("async_rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         check($sformatf("quiet_busy c%0d", c), int'(bz), 0);
         check($sformatf("quiet_bit c%0d", c), int'(bo), 15);
      end
      check_all_reset("quiet_end");
      write_single(8'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
